// File: rtl/f8_dot_seq.sv
// f8_dot_seq: sequential Float8 dot product over two 1-cycle-latency memories via an external multiplier.
// Optional F8_DOT_RELU_EN: negative accumulator results are forced to 0x00.
module f8_dot_seq #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [LEN_W-1:0] iLen,
    output logic             oRdEn,
    output logic [LEN_W-1:0] oAddr,
    input  logic [7:0]       iWgt,
    input  logic [7:0]       iAct,
    output logic [7:0]       oMulA,
    output logic [7:0]       oMulB,
    input  logic [7:0]       iMulP,
    output logic             oBusy,
    output logic             oValid,
    output logic [7:0]       oResult,
    input  logic             iAck
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic signed [ACC_W:0] SAT = {2'b00, {(ACC_W-1){1'b1}}};

    state_t state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, addr_q, addr_d;
    logic drain_q, drain_d, v1_q, v1_d, v2_q, v2_d;
    logic [7:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, result_q, result_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod;
    logic signed [ACC_W:0] sum, sat;
    logic [ACC_W-1:0] mag;
    logic [6:0] mag7;
    logic start, last;

    assign start = (state_q == IDLE) && iStart;
    assign last  = addr_q == len_q - LEN_W'(1);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = iStart ? ((iLen == '0) ? DONE : RUN) : IDLE;
            RUN:     state_d = last ? DRAIN : RUN;
            DRAIN:   state_d = drain_q ? DONE : DRAIN;
            default: state_d = iAck ? IDLE : DONE;
        endcase
    end

    always_comb begin
        oBusy  = (state_q == RUN) || (state_q == DRAIN);
        oValid = state_q == DONE;
        oRdEn  = state_q == RUN;
    end

    // Pipe: read issue -> memory data (v1) -> multiplier operands (v2) -> accumulate
    always_comb begin
        len_d    = start ? iLen : len_q;
        addr_d   = (state_q == RUN && !last) ? addr_q + LEN_W'(1) : '0;
        drain_d  = (state_q == DRAIN) && !drain_q;
        v1_d     = state_q == RUN;
        v2_d     = v1_q;
        mul_a_d  = v1_q ? iWgt : 8'h00;
        mul_b_d  = v1_q ? iAct : 8'h00;
        prod     = (iMulP == 8'h80) ? ACC_W'(128) :
                   iMulP[7] ? -ACC_W'(iMulP[6:0]) : ACC_W'(iMulP[6:0]);
        sum      = {acc_q[ACC_W-1], acc_q} + {prod[ACC_W-1], prod};
        sat      = (sum > SAT) ? SAT : ((sum < -SAT) ? -SAT : sum);
        acc_d    = start ? '0 : (v2_q ? sat[ACC_W-1:0] : acc_q);
        mag      = acc_d[ACC_W-1] ? -acc_d : acc_d;
        mag7     = (mag > ACC_W'(127)) ? 7'h7F : mag[6:0];
        result_d = result_q;
        if (state_d == DONE && state_q != DONE) begin
`ifdef F8_DOT_RELU_EN
            result_d = acc_d[ACC_W-1] ? 8'h00 : {1'b0, mag7};
`else
            result_d = {acc_d[ACC_W-1], mag7};
`endif
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            len_q    <= '0;
            addr_q   <= '0;
            drain_q  <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            len_q    <= len_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign oAddr   = addr_q;
    assign oMulA   = mul_a_q;
    assign oMulB   = mul_b_q;
    assign oResult = result_q;
endmodule
